cardinal_nic: RTL and testbench

- Network interface controller at the local (NIC) port of a cardinal_router; it is the opposite endpoint of the router's NIC channel.
- Injects processor-written flits into the router's NIC input and drains flits the router delivers to its NIC output.
- Processor side is a 4-register memory-mapped interface, each direction is one-entry buffered, and injection is gated by the router's polarity_to_NIC.

---
 rtl/cardinal_nic.sv | 93 +++++++++
 tb/tb_cardinal_nic.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// rtl/cardinal_nic.sv - Local-port NIC for cardinal_router: one-entry inject/drain buffers behind four processor registers
module cardinal_nic #(
    parameter int DW     = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DW-1:0]     d_in,
    output logic [DW-1:0]     d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    input  logic [DW-1:0]     net_di,
    output logic              net_ro,
    output logic              net_so,
    output logic [DW-1:0]     net_do,
    input  logic              net_ri,
    input  logic              net_polarity
);

    localparam logic [ADDR_W-1:0] A_IN_BUF   = 2'b00;
    localparam logic [ADDR_W-1:0] A_IN_STAT  = 2'b01;
    localparam logic [ADDR_W-1:0] A_OUT_BUF  = 2'b10;
    localparam logic [ADDR_W-1:0] A_OUT_STAT = 2'b11;

    logic          in_full;
    logic          out_full;
    logic [DW-1:0] in_buf;
    logic [DW-1:0] out_buf;
    logic          rd_en;
    logic          wr_en;
    logic          send;

    assign rd_en = nicEn & ~nicWrEn;
    assign wr_en = nicEn & nicWrEn;

    // A flit only leaves when the router has room and its vc bit matches the router's current polarity.
    assign send   = out_full & net_ri & (out_buf[DW-1] == net_polarity);
    assign net_so = send;
    assign net_do = send ? out_buf : '0;
    assign net_ro = ~in_full;

    // Receive path: capture while empty, clear when software reads IN_BUF.
    // The two never coincide because capture needs empty and clear needs full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_full <= 1'b0;
            in_buf  <= '0;
        end else begin
            if (net_si && !in_full) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end
            if (rd_en && (addr == A_IN_BUF) && in_full) begin
                in_full <= 1'b0;
            end
        end
    end

    // Send path: accept an OUT_BUF write only while empty; the router consuming the flit empties it.
    // A write in the same cycle as a send sees the pre-edge full flag and is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_full <= 1'b0;
            out_buf  <= '0;
        end else begin
            if (wr_en && (addr == A_OUT_BUF) && !out_full) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end
            if (send) begin
                out_full <= 1'b0;
            end
        end
    end

    // Registered read data; holds its value when no read is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out <= '0;
        end else if (rd_en) begin
            case (addr)
                A_IN_BUF:   d_out <= in_buf;
                A_IN_STAT:  d_out <= {{(DW-1){1'b0}}, in_full};
                A_OUT_BUF:  d_out <= out_buf;
                A_OUT_STAT: d_out <= {{(DW-1){1'b0}}, out_full};
                default:    d_out <= d_out;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// tb/tb_cardinal_nic.sv - Directed and randomized checks of cardinal_nic against a register-level reference model
module tb_cardinal_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic [63:0] net_di;
    logic        net_ro;
    logic        net_so;
    logic [63:0] net_do;
    logic        net_ri;
    logic        net_polarity;

    int checks = 0;
    int errors = 0;

    // Reference model: what software and the router can observe.
    logic        m_in_full, m_out_full;
    logic [63:0] m_in_data, m_out_data, m_dout;

    localparam logic [63:0] F1 = 64'hA00A_2000_0000_1234;
    localparam logic [63:0] F2 = 64'h8123_0000_0000_0055;
    localparam logic [63:0] F3 = 64'h8FFF_0000_0000_0077;
    localparam logic [63:0] F4 = 64'h0012_0000_0000_0001;
    localparam logic [63:0] F5 = 64'h0034_0000_0000_0002;
    localparam logic [63:0] F6 = 64'h4000_1100_0000_00AA;
    localparam logic [63:0] R0 = 64'h8000_0000_DEAD_BEEF;
    localparam logic [63:0] R1 = 64'h1111_0000_0000_2222;
    localparam logic [63:0] R2 = 64'h3333_0000_0000_4444;
    localparam logic [63:0] R3 = 64'h5555_0000_0000_6666;

    cardinal_nic #(.DW(64), .ADDR_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_di       (net_di),
        .net_ro       (net_ro),
        .net_so       (net_so),
        .net_do       (net_do),
        .net_ri       (net_ri),
        .net_polarity (net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_full  = 1'b0;
        m_out_full = 1'b0;
        m_in_data  = '0;
        m_out_data = '0;
        m_dout     = '0;
    endtask

    task automatic set_in(input logic [1:0] a, input logic e, input logic w, input logic [63:0] din,
                          input logic si, input logic [63:0] di, input logic ri, input logic pol);
        addr = a; nicEn = e; nicWrEn = w; d_in = din;
        net_si = si; net_di = di; net_ri = ri; net_polarity = pol;
    endtask

    // Check combinational outputs against the model, advance the model over one edge, check read data.
    task automatic tick();
        logic        snd;
        logic        n_in_full, n_out_full;
        logic [63:0] n_in_data, n_out_data, n_dout;
        #2;
        snd = m_out_full && net_ri && (m_out_data[63] == net_polarity);
        chk("net_ro", {63'b0, net_ro}, {63'b0, !m_in_full});
        chk("net_so", {63'b0, net_so}, {63'b0, snd});
        chk("net_do", net_do, snd ? m_out_data : 64'h0);
        n_in_full = m_in_full; n_out_full = m_out_full;
        n_in_data = m_in_data; n_out_data = m_out_data; n_dout = m_dout;
        if (net_si && !m_in_full) begin
            n_in_data = net_di;
            n_in_full = 1'b1;
        end
        if (nicEn && !nicWrEn) begin
            if (addr == 2'd0) begin
                n_dout = m_in_data;
                if (m_in_full) n_in_full = 1'b0;
            end else if (addr == 2'd1) n_dout = {63'b0, m_in_full};
            else if (addr == 2'd2)     n_dout = m_out_data;
            else                       n_dout = {63'b0, m_out_full};
        end
        if (nicEn && nicWrEn && addr == 2'd2 && !m_out_full) begin
            n_out_data = d_in;
            n_out_full = 1'b1;
        end
        if (snd) n_out_full = 1'b0;
        @(posedge clk);
        #1;
        m_in_full = n_in_full; m_out_full = n_out_full;
        m_in_data = n_in_data; m_out_data = n_out_data; m_dout = n_dout;
        chk("d_out", d_out, m_dout);
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        set_in(2'd0, 0, 0, 64'h0, 0, 64'h0, 0, 0);

        // 1. reset state
        #12;
        chk("rst_net_ro", {63'b0, net_ro}, 64'h1);
        chk("rst_net_so", {63'b0, net_so}, 64'h0);
        chk("rst_d_out", d_out, 64'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        set_in(2'd1, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("rst_in_stat", d_out, 64'h0);
        set_in(2'd3, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("rst_out_stat", d_out, 64'h0);

        // 2. injection gated by polarity
        set_in(2'd2, 1, 1, F1, 0, 64'h0, 1, 0); tick();
        set_in(2'd0, 0, 0, 64'h0, 0, 64'h0, 1, 0); #1;
        chk("pol_block_so", {63'b0, net_so}, 64'h0);
        tick();
        set_in(2'd0, 0, 0, 64'h0, 0, 64'h0, 1, 1); #1;
        chk("pol_match_so", {63'b0, net_so}, 64'h1);
        chk("pol_match_do", net_do, F1);
        tick();
        chk("sent_once_so", {63'b0, net_so}, 64'h0);
        set_in(2'd3, 1, 0, 64'h0, 0, 64'h0, 1, 1); tick();
        chk("sent_out_stat", d_out, 64'h0);

        // 3. backpressure: second write dropped while full
        set_in(2'd2, 1, 1, F2, 0, 64'h0, 0, 1); tick();
        set_in(2'd2, 1, 1, F3, 0, 64'h0, 0, 1); #1;
        chk("bp_so", {63'b0, net_so}, 64'h0);
        tick();
        set_in(2'd2, 1, 0, 64'h0, 0, 64'h0, 0, 1); tick();
        chk("bp_drop_buf", d_out, F2);
        set_in(2'd0, 0, 0, 64'h0, 0, 64'h0, 1, 1); #1;
        chk("bp_release_do", net_do, F2);
        tick();

        // send and OUT_BUF write in the same cycle: write dropped
        set_in(2'd2, 1, 1, F4, 0, 64'h0, 0, 0); tick();
        set_in(2'd2, 1, 1, F5, 0, 64'h0, 1, 0); #1;
        chk("coll_do", net_do, F4);
        tick();
        set_in(2'd3, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("coll_out_stat", d_out, 64'h0);
        set_in(2'd2, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("coll_out_buf", d_out, F4);

        // 4. receive and drain
        set_in(2'd0, 0, 0, 64'h0, 1, R0, 0, 0); tick();
        set_in(2'd1, 1, 0, 64'h0, 0, 64'h0, 0, 0); #1;
        chk("rx_ro_low", {63'b0, net_ro}, 64'h0);
        tick();
        chk("rx_in_stat", d_out, 64'h1);
        set_in(2'd0, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("rx_in_buf", d_out, R0);
        chk("rx_ro_high", {63'b0, net_ro}, 64'h1);
        set_in(2'd1, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("rx_in_stat_clr", d_out, 64'h0);

        // 5. full receiver holds first flit, second captured after drain
        set_in(2'd0, 0, 0, 64'h0, 1, R1, 0, 0); tick();
        set_in(2'd0, 0, 0, 64'h0, 1, R2, 0, 0); tick();
        tick();
        set_in(2'd0, 1, 0, 64'h0, 1, R2, 0, 0); tick();
        chk("full_no_ovwr", d_out, R1);
        set_in(2'd0, 0, 0, 64'h0, 1, R2, 0, 0); tick();
        set_in(2'd0, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("full_second", d_out, R2);

        // 6. async reset with both buffers occupied
        set_in(2'd2, 1, 1, F6, 1, R3, 0, 0); tick();
        set_in(2'd0, 0, 0, 64'h0, 0, 64'h0, 1, 0); #1;
        chk("pre_rst_so", {63'b0, net_so}, 64'h1);
        chk("pre_rst_ro", {63'b0, net_ro}, 64'h0);
        reset = 1'b0; #1;
        model_reset();
        chk("arst_so", {63'b0, net_so}, 64'h0);
        chk("arst_ro", {63'b0, net_ro}, 64'h1);
        chk("arst_d_out", d_out, 64'h0);
        net_ri = 1'b0;
        #1 reset = 1'b1;
        tick();
        set_in(2'd1, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("arst_in_stat", d_out, 64'h0);
        set_in(2'd3, 1, 0, 64'h0, 0, 64'h0, 0, 0); tick();
        chk("arst_out_stat", d_out, 64'h0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            set_in(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
